// File: rtl/neuron_mac_accumulator.sv
// Streaming MAC neuron stage: one 8x8 unsigned product per accepted beat,
// N_INPUTS products plus a bias accumulated, scaled by SHIFT and clamped to
// an 8-bit activation presented on a valid/ready output.

// Unsigned 8x8 multiplier, purely combinational.
module multiplier_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);

  // Shift-and-add: one partial product per multiplier bit.
  always_comb begin
    product = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) begin
        product = product + (16'(a) << i);
      end
    end
  end

endmodule

module neuron_mac_accumulator #(
  parameter int N_INPUTS = 16,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_w,
  input  logic [15:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_y,
  output logic        out_sat,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    ST_ACC,
    ST_FLUSH,
    ST_HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      mult_p;
  logic [15:0]      prod_q;
  logic             prod_v;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      bias_q;

  logic             accept;
  logic             out_fire;

  logic [ACC_W-1:0] sum_flush;
  logic [ACC_W-1:0] sum_shr;
  logic             sat_flush;
  logic [7:0]       y_flush;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  multiplier_8bit u_mult (
    .a       (in_x),
    .b       (in_w),
    .product (mult_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: last beat -> one flush cycle -> hold until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC: begin
        if (accept && (cnt == CNT_LAST)) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_fire) begin
          state_nxt = ST_ACC;
        end
      end
      default: begin
        state_nxt = ST_ACC;
      end
    endcase
  end

  // State-decoded outputs; in_ready deliberately ignores out_ready.
  always_comb begin
    in_ready = (state == ST_ACC);
    busy     = (state != ST_ACC) || (cnt != '0);
  end

  // Product pipeline register; a pending product is consumed every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      prod_v <= 1'b0;
    end else if (out_fire) begin
      prod_v <= 1'b0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod_q <= mult_p;
      end
    end
  end

  // Accumulator; the final product is folded in by the flush sum instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (out_fire) begin
      acc <= '0;
    end else if (prod_v && (state == ST_ACC)) begin
      acc <= acc + ACC_W'(prod_q);
    end
  end

  // Beat counter; parks at the last index until the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (out_fire) begin
      cnt <= '0;
    end else if (accept && (cnt != CNT_LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Bias captured with the first beat of each vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q <= '0;
    end else if (accept && (cnt == '0)) begin
      bias_q <= bias;
    end
  end

  // Biased sum, scaled and clamped to the 8-bit activation range.
  always_comb begin
    sum_flush = acc + ACC_W'(prod_q) + ACC_W'(bias_q);
    sum_shr   = sum_flush >> SHIFT;
    sat_flush = |sum_shr[ACC_W-1:8];
    y_flush   = sat_flush ? 8'hFF : sum_shr[7:0];
  end

  // Result register: loaded on flush, held until the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_sat   <= 1'b0;
    end else if (state == ST_FLUSH) begin
      out_valid <= 1'b1;
      out_y     <= y_flush;
      out_sat   <= sat_flush;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Scoreboard bench for neuron_mac_accumulator: a transaction-level model
// predicts each activation from accepted beats, a monitor checks outputs.
module tb_neuron_mac_accumulator;

  localparam int N  = 16;
  localparam int SH = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x      = '0;
  logic [7:0]  in_w      = '0;
  logic [15:0] bias      = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_y;
  logic        out_sat;
  logic        busy;

  neuron_mac_accumulator #(
    .N_INPUTS (N),
    .ACC_W    (24),
    .SHIFT    (SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected results.
  int sb_y[$];
  int sb_sat[$];

  function automatic void push_exp(input int s);
    int v;
    v = s >> SH;
    sb_y.push_back(v > 255 ? 255 : v);
    sb_sat.push_back(v > 255 ? 1 : 0);
  endfunction

  // Transaction model: 0 = collecting beats, 1 = flush, 2 = holding result.
  int m_state = 0;
  int m_cnt   = 0;
  int m_sum   = 0;
  int last_acc_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_state = 0;
      m_cnt   = 0;
      m_sum   = 0;
    end else begin
      chk("in_ready", int'(in_ready), (m_state == 0) ? 1 : 0);
      chk("out_valid", int'(out_valid), (m_state == 2) ? 1 : 0);
      chk("busy", int'(busy), (m_state != 0 || m_cnt != 0) ? 1 : 0);
      case (m_state)
        0: if (in_valid) begin
          if (m_cnt == 0) m_sum = int'(bias);
          m_sum = m_sum + int'(in_x) * int'(in_w);
          m_cnt++;
          if (m_cnt == N) begin
            push_exp(m_sum);
            last_acc_cyc = cyc + 1;
            m_state = 1;
          end
        end
        1: m_state = 2;
        default: if (out_ready) begin
          m_state = 0;
          m_cnt   = 0;
        end
      endcase
    end
  end

  // Output monitor: stability while held, scoreboard compare on handshake.
  bit held       = 0;
  bit prev_valid = 0;
  int held_y     = 0;
  int held_sat   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held       = 0;
      prev_valid = 0;
    end else begin
      if (out_valid && !prev_valid) chk("latency", cyc - last_acc_cyc, 1);
      if (out_valid) begin
        if (held) begin
          chk("hold_y", int'(out_y), held_y);
          chk("hold_sat", int'(out_sat), held_sat);
        end else begin
          held     = 1;
          held_y   = int'(out_y);
          held_sat = int'(out_sat);
        end
        if (out_ready) begin
          if (sb_y.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            chk("out_y", int'(out_y), sb_y.pop_front());
            chk("out_sat", int'(out_sat), sb_sat.pop_front());
          end
          held = 0;
        end
      end
      prev_valid = out_valid;
    end
  end

  // Optional random backpressure.
  bit rnd_ready = 0;
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int x, input int w, input int b, input int idle);
    bit took;
    took     = 0;
    in_valid = 1'b1;
    in_x     = 8'(x);
    in_w     = 8'(w);
    bias     = 16'(b);
    for (int k = 0; k < 200 && !took; k++) begin
      @(negedge clk);
      took = in_ready;
      step();
    end
    if (!took) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_w     = 8'($urandom);
    bias     = 16'($urandom);
    repeat (idle) step();
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = (sb_y.size() == 0) && (m_state == 0) && (m_cnt == 0);
    end
    chk("drain_pending", sb_y.size(), 0);
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_y"}, int'(out_y), 0);
    chk({tag, "_out_sat"}, int'(out_sat), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int bx;
    int bw;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();

    // Unit products, back to back.
    for (int i = 0; i < N; i++) beat(1, 1, 0, 0);
    drain();

    // Full-scale saturation.
    for (int i = 0; i < N; i++) beat(255, 255, 0, 0);
    drain();

    // Bubbles plus bias.
    for (int i = 0; i < N; i++) beat(i, 2, 16, $urandom_range(0, 3));
    drain();

    // Backpressure with in_valid held high, then a vector after release.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535), 0);
    in_valid = 1'b1;
    in_x     = 8'd2;
    in_w     = 8'd2;
    bias     = 16'd0;
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    step();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) beat(2, 2, 0, 0);
    drain();

    // Beat offered on the handshake edge becomes beat 0 of the next vector.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) beat($urandom_range(0, 255), $urandom_range(0, 255), 500, 0);
    wait_valid();
    step();
    bx        = $urandom_range(1, 255);
    bw        = $urandom_range(1, 255);
    out_ready = 1'b1;
    beat(bx, bw, 77, 0);
    for (int i = 1; i < N; i++) beat($urandom_range(0, 255), $urandom_range(0, 255), 9999, 0);
    drain();

    // Reset mid-vector discards the partial sum.
    for (int i = 0; i < 7; i++) beat(255, 255, 0, 0);
    rst_n = 1'b0;
    chk_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) beat(1, 1, 0, 0);
    drain();

    // Random vectors with random bubbles and backpressure.
    rnd_ready = 1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++)
        beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 2));
    end
    rnd_ready = 0;
    step();
    step();
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
